// File: rtl/serv_wb_arbiter.sv
// Two-master Wishbone arbiter: SERV ibus and dbus share one CPU-side bus, round robin on contention.
// Define SERV_ARB_TIMEOUT_EN to add a watchdog that terminates transfers no slave acknowledges.
module serv_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_cyc,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_cyc,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  output logic [31:0] o_wb_cpu_adr,
  output logic [31:0] o_wb_cpu_dat,
  output logic [3:0]  o_wb_cpu_sel,
  output logic        o_wb_cpu_we,
  output logic        o_wb_cpu_cyc,
  input  logic [31:0] i_wb_cpu_rdt,
  input  logic        i_wb_cpu_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t state_r;
  logic   last_d_r;
  logic   gnt_i_s;
  logic   gnt_d_s;
  logic   gnt_cyc_s;
  logic   expire_s;
  logic   done_s;

  assign gnt_i_s   = (state_r == GNT_I);
  assign gnt_d_s   = (state_r == GNT_D);
  assign gnt_cyc_s = (gnt_i_s & i_wb_ibus_cyc) | (gnt_d_s & i_wb_dbus_cyc);

`ifdef SERV_ARB_TIMEOUT_EN
  logic [15:0] count_r;

  // Watchdog: restarts in IDLE so every grant begins counting from zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= 16'd0;
    end else if (state_r == IDLE) begin
      count_r <= 16'd0;
    end else if (!i_wb_cpu_ack) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // A real slave ack in the expiry cycle wins, so no timeout is flagged then
  assign expire_s = gnt_cyc_s & (count_r == TO_LAST) & ~i_wb_cpu_ack;
`else
  logic unused_s;
  assign unused_s = ^TO_LAST;
  assign expire_s = 1'b0;
`endif

  assign done_s = i_wb_cpu_ack | expire_s;

  // Grant FSM; last_d_r only moves on a completed transfer, never on abort
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      last_d_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_wb_ibus_cyc && (!i_wb_dbus_cyc || last_d_r)) begin
            state_r <= GNT_I;
          end else if (i_wb_dbus_cyc) begin
            state_r <= GNT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        GNT_I: begin
          if (done_s) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
          end else if (!i_wb_ibus_cyc) begin
            state_r <= IDLE;
          end else begin
            state_r <= GNT_I;
          end
        end
        GNT_D: begin
          if (done_s) begin
            state_r  <= IDLE;
            last_d_r <= 1'b1;
          end else if (!i_wb_dbus_cyc) begin
            state_r <= IDLE;
          end else begin
            state_r <= GNT_D;
          end
        end
        default: begin
          state_r  <= IDLE;
          last_d_r <= 1'b1;
        end
      endcase
    end
  end

  // Shared bus mux; ibus is read-only so it presents full-word reads
  always_comb begin
    o_wb_cpu_adr = i_wb_dbus_adr;
    o_wb_cpu_dat = i_wb_dbus_dat;
    o_wb_cpu_sel = i_wb_dbus_sel;
    o_wb_cpu_we  = i_wb_dbus_we;
    if (gnt_i_s) begin
      o_wb_cpu_adr = i_wb_ibus_adr;
      o_wb_cpu_dat = 32'h0000_0000;
      o_wb_cpu_sel = 4'hf;
      o_wb_cpu_we  = 1'b0;
    end else begin
      o_wb_cpu_adr = i_wb_dbus_adr;
    end
  end

  assign o_wb_cpu_cyc  = gnt_cyc_s;
  assign o_wb_ibus_ack = gnt_i_s & done_s;
  assign o_wb_dbus_ack = gnt_d_s & done_s;
  assign o_wb_ibus_rdt = expire_s ? 32'h0000_0000 : i_wb_cpu_rdt;
  assign o_wb_dbus_rdt = expire_s ? 32'h0000_0000 : i_wb_cpu_rdt;
  assign o_timeout     = expire_s;

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Directed bench for serv_wb_arbiter: scoreboard of expected shared-bus transfers plus per-cycle checks.
module tb_serv_wb_arbiter;

  typedef struct {
    logic        d;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } exp_t;

  localparam logic [31:0] RDT_KEY = 32'h5a5a_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_wb_ibus_adr = 32'h0;
  logic        i_wb_ibus_cyc = 1'b0;
  logic [31:0] o_wb_ibus_rdt;
  logic        o_wb_ibus_ack;
  logic [31:0] i_wb_dbus_adr = 32'h0;
  logic [31:0] i_wb_dbus_dat = 32'h0;
  logic [3:0]  i_wb_dbus_sel = 4'h0;
  logic        i_wb_dbus_we = 1'b0;
  logic        i_wb_dbus_cyc = 1'b0;
  logic [31:0] o_wb_dbus_rdt;
  logic        o_wb_dbus_ack;
  logic [31:0] o_wb_cpu_adr;
  logic [31:0] o_wb_cpu_dat;
  logic [3:0]  o_wb_cpu_sel;
  logic        o_wb_cpu_we;
  logic        o_wb_cpu_cyc;
  logic [31:0] i_wb_cpu_rdt;
  logic        i_wb_cpu_ack;
  logic        o_timeout;
  logic        ack_en = 1'b0;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  serv_wb_arbiter #(.TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_ibus_adr(i_wb_ibus_adr), .i_wb_ibus_cyc(i_wb_ibus_cyc),
    .o_wb_ibus_rdt(o_wb_ibus_rdt), .o_wb_ibus_ack(o_wb_ibus_ack),
    .i_wb_dbus_adr(i_wb_dbus_adr), .i_wb_dbus_dat(i_wb_dbus_dat),
    .i_wb_dbus_sel(i_wb_dbus_sel), .i_wb_dbus_we(i_wb_dbus_we),
    .i_wb_dbus_cyc(i_wb_dbus_cyc),
    .o_wb_dbus_rdt(o_wb_dbus_rdt), .o_wb_dbus_ack(o_wb_dbus_ack),
    .o_wb_cpu_adr(o_wb_cpu_adr), .o_wb_cpu_dat(o_wb_cpu_dat),
    .o_wb_cpu_sel(o_wb_cpu_sel), .o_wb_cpu_we(o_wb_cpu_we),
    .o_wb_cpu_cyc(o_wb_cpu_cyc),
    .i_wb_cpu_rdt(i_wb_cpu_rdt), .i_wb_cpu_ack(i_wb_cpu_ack),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Single-cycle slave: acks whenever a cycle is presented and acks are enabled
  assign i_wb_cpu_ack = ack_en & o_wb_cpu_cyc;
  assign i_wb_cpu_rdt = o_wb_cpu_adr ^ RDT_KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic push(input logic d, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we);
    exp_t e;
    e.d = d; e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
    sb.push_back(e);
  endtask

  // Scoreboard: every slave-acked transfer must match the next expected grant
  always @(negedge i_clk) begin
    if (o_wb_cpu_cyc && i_wb_cpu_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_xfer", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ibus_ack", {31'd0, o_wb_ibus_ack}, {31'd0, ~e.d});
        chk("sb_dbus_ack", {31'd0, o_wb_dbus_ack}, {31'd0, e.d});
        chk("sb_adr", o_wb_cpu_adr, e.adr);
        chk("sb_dat", o_wb_cpu_dat, e.dat);
        chk("sb_sel", {28'd0, o_wb_cpu_sel}, {28'd0, e.sel});
        chk("sb_we", {31'd0, o_wb_cpu_we}, {31'd0, e.we});
        chk("sb_rdt", e.d ? o_wb_dbus_rdt : o_wb_ibus_rdt, e.adr ^ RDT_KEY);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset
    tick(); tick();
    i_rst = 1'b0;
    settle();
    chk("rst_cyc", {31'd0, o_wb_cpu_cyc}, 32'd0);
    chk("rst_iack", {31'd0, o_wb_ibus_ack}, 32'd0);
    chk("rst_dack", {31'd0, o_wb_dbus_ack}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);

    // ibus read, single-cycle slave
    tick();
    ack_en = 1'b1;
    i_wb_ibus_adr = 32'h0000_0100;
    i_wb_ibus_cyc = 1'b1;
    push(1'b0, 32'h0000_0100, 32'h0, 4'hf, 1'b0);
    settle();
    chk("i_c1_cyc", {31'd0, o_wb_cpu_cyc}, 32'd0);
    chk("i_c1_ack", {31'd0, o_wb_ibus_ack}, 32'd0);
    tick(); settle();
    chk("i_c2_cyc", {31'd0, o_wb_cpu_cyc}, 32'd1);
    chk("i_c2_ack", {31'd0, o_wb_ibus_ack}, 32'd1);
    tick();
    i_wb_ibus_cyc = 1'b0;
    settle();
    chk("i_after_cyc", {31'd0, o_wb_cpu_cyc}, 32'd0);

    // dbus write
    i_wb_dbus_adr = 32'h4000_0000;
    i_wb_dbus_dat = 32'h0000_0001;
    i_wb_dbus_sel = 4'h1;
    i_wb_dbus_we  = 1'b1;
    i_wb_dbus_cyc = 1'b1;
    push(1'b1, 32'h4000_0000, 32'h0000_0001, 4'h1, 1'b1);
    tick(); settle();
    chk("d_cyc", {31'd0, o_wb_cpu_cyc}, 32'd1);
    chk("d_iack", {31'd0, o_wb_ibus_ack}, 32'd0);
    tick();
    i_wb_dbus_cyc = 1'b0;
    i_wb_dbus_we  = 1'b0;

    // Both masters requesting continuously: I, D, I, D with IDLE between
    i_wb_ibus_adr = 32'h0000_0200;
    i_wb_dbus_adr = 32'h0000_0300;
    i_wb_dbus_dat = 32'h0;
    i_wb_dbus_sel = 4'hf;
    i_wb_ibus_cyc = 1'b1;
    i_wb_dbus_cyc = 1'b1;
    push(1'b0, 32'h0000_0200, 32'h0, 4'hf, 1'b0);
    push(1'b1, 32'h0000_0300, 32'h0, 4'hf, 1'b0);
    push(1'b0, 32'h0000_0200, 32'h0, 4'hf, 1'b0);
    push(1'b1, 32'h0000_0300, 32'h0, 4'hf, 1'b0);
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("rr_cyc%0d", k), {31'd0, o_wb_cpu_cyc}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    i_wb_ibus_cyc = 1'b0;
    i_wb_dbus_cyc = 1'b0;

    // dbus arrives while ibus waits on a slow slave
    ack_en = 1'b0;
    i_wb_ibus_adr = 32'h0000_0400;
    i_wb_ibus_cyc = 1'b1;
    push(1'b0, 32'h0000_0400, 32'h0, 4'hf, 1'b0);
    tick();
    i_wb_dbus_adr = 32'h0000_0500;
    i_wb_dbus_cyc = 1'b1;
    push(1'b1, 32'h0000_0500, 32'h0, 4'hf, 1'b0);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("wait_adr", o_wb_cpu_adr, 32'h0000_0400);
      chk("wait_dack", {31'd0, o_wb_dbus_ack}, 32'd0);
      tick();
    end
    ack_en = 1'b1;
    settle();
    chk("wait_iack", {31'd0, o_wb_ibus_ack}, 32'd1);
    tick();
    i_wb_ibus_cyc = 1'b0;
    settle();
    chk("wait_idle", {31'd0, o_wb_cpu_cyc}, 32'd0);
    tick(); settle();
    chk("wait_dgnt", {31'd0, o_wb_dbus_ack}, 32'd1);
    tick();
    i_wb_dbus_cyc = 1'b0;

    // ibus abort: last_d stays 1, so ibus wins the following tie
    ack_en = 1'b0;
    i_wb_ibus_adr = 32'h0000_0600;
    i_wb_ibus_cyc = 1'b1;
    tick(); settle();
    chk("abort_gnt", {31'd0, o_wb_cpu_cyc}, 32'd1);
    tick();
    i_wb_ibus_cyc = 1'b0;
    settle();
    chk("abort_cyc", {31'd0, o_wb_cpu_cyc}, 32'd0);
    tick();
    ack_en = 1'b1;
    i_wb_ibus_adr = 32'h0000_0610;
    i_wb_dbus_adr = 32'h0000_0620;
    i_wb_ibus_cyc = 1'b1;
    i_wb_dbus_cyc = 1'b1;
    push(1'b0, 32'h0000_0610, 32'h0, 4'hf, 1'b0);
    push(1'b1, 32'h0000_0620, 32'h0, 4'hf, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    i_wb_ibus_cyc = 1'b0;
    i_wb_dbus_cyc = 1'b0;

    // Reset mid-transfer drops the cycle
    ack_en = 1'b0;
    i_wb_dbus_cyc = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_wb_dbus_cyc = 1'b0;
    settle();
    chk("rst_mid_cyc", {31'd0, o_wb_cpu_cyc}, 32'd0);
    tick();

    // Never-acking slave
    i_wb_ibus_adr = 32'h0000_0700;
    i_wb_ibus_cyc = 1'b1;
    tick();
`ifdef SERV_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk($sformatf("to_iack%0d", k), {31'd0, o_wb_ibus_ack}, (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("to_pulse%0d", k), {31'd0, o_timeout}, (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) chk("to_rdt", o_wb_ibus_rdt, 32'h0);
      tick();
    end
    settle();
    chk("to_idle", {31'd0, o_wb_cpu_cyc}, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      settle();
      chk("hang_cyc", {31'd0, o_wb_cpu_cyc}, 32'd1);
      chk("hang_iack", {31'd0, o_wb_ibus_ack}, 32'd0);
      chk("hang_pulse", {31'd0, o_timeout}, 32'd0);
      tick();
    end
`endif
    i_wb_ibus_cyc = 1'b0;
    tick(); settle();
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
